v810_ifetch: RTL and testbench

V810_IFETCH -- requirements
Module: v810_ifetch

---
 rtl/v810_pkg.sv | 22 ++
 rtl/v810_ifq.sv | 64 ++++++
 rtl/v810_ifetch.sv | 142 ++++++++++++++
 tb/tb_v810_ifetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/v810_pkg.sv
// Shared definitions for the V810 instruction fetch unit: reset vector, FSM states, queue-count width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package v810_pkg;

    localparam logic [31:0] V810_RESET_PC = 32'hFFFF_FFF0;
    localparam int          V810_QDEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fstate_t;

    // A queue of 'depth' halfwords needs to represent 0..depth inclusive.
    function automatic int qcnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int V810_QCNT_W = qcnt_width(V810_QDEPTH);

endpackage

// File: rtl/v810_ifq.sv
// Halfword prefetch queue: writes 0..2 halfwords, reads 0..2 halfwords, flush, count output.
// Latency: written halfwords visible on o_head one cycle after the write.
// Backpressure: none internally; the writer must keep count + writes <= DEPTH, the reader must not exceed count.
module v810_ifq
    import v810_pkg::*;
#(
    parameter int DEPTH = V810_QDEPTH,
    parameter int CW    = qcnt_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic [1:0]    i_wr_n,
    input  logic [31:0]   i_wr_dat,
    input  logic [1:0]    i_rd_n,
    output logic [31:0]   o_head,
    output logic [CW-1:0] o_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    // DEPTH is only required to be even, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                r_rd  <= ptr_add(r_rd, i_rd_n);
                r_wr  <= ptr_add(r_wr, i_wr_n);
                r_cnt <= r_cnt + CW'(i_wr_n) - CW'(i_rd_n);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en && !i_flush) begin
            if (i_wr_n != 2'd0) r_mem[r_wr] <= i_wr_dat[15:0];
            if (i_wr_n == 2'd2) r_mem[ptr_add(r_wr, 2'd1)] <= i_wr_dat[31:16];
        end
    end

    assign o_head = {r_mem[ptr_add(r_rd, 2'd1)], r_mem[r_rd]};
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/v810_ifetch.sv
// V810 instruction fetch: word fetcher feeding a halfword queue to the decoder, with redirect handling.
// Latency: fetched halfwords reach QD/QV the cycle after EUIACK; redirect empties QV the next cycle.
// Backpressure: EUIREQ only starts when the queue has room for a full word; an issued request is held until EUIACK.
module v810_ifetch
    import v810_pkg::*;
#(
    parameter int          QDEPTH   = V810_QDEPTH,
    parameter logic [31:0] RESET_PC = V810_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        JMP,
    input  logic [31:0] JMPA,
    output logic [31:0] EUIA,
    output logic        EUIREQ,
    input  logic [31:0] EUID,
    input  logic        EUIACK,
    output logic [31:0] QD,
    output logic [31:0] QPC,
    output logic [1:0]  QV,
    input  logic [1:0]  QCONS
);

    localparam int CW = qcnt_width(QDEPTH);

    fstate_t       r_state;
    logic [31:0]   r_fa;
    logic [31:0]   r_euia;
    logic [31:0]   r_qpc;
    logic          r_req;
    logic          r_skip;

    logic [CW-1:0] w_cnt;
    logic [CW:0]   w_cnt_nxt;
    logic [1:0]    w_qv;
    logic [1:0]    w_cons;
    logic [1:0]    w_wr_n;
    logic [31:0]   w_wr_dat;
    logic          w_ack_ok;
    logic          w_room;
    logic          w_unused_jmpa0;

    assign w_unused_jmpa0 = JMPA[0];

    always_comb begin
        w_qv      = (w_cnt >= CW'(2)) ? 2'd2 : w_cnt[1:0];
        w_cons    = JMP ? 2'd0 : ((QCONS > w_qv) ? w_qv : QCONS);
        w_ack_ok  = (r_state == ST_FETCH) && EUIACK && !JMP;
        w_wr_n    = w_ack_ok ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
        w_wr_dat  = r_skip ? {16'h0000, EUID[31:16]} : EUID;
        w_cnt_nxt = {1'b0, w_cnt} + (CW+1)'(w_wr_n) - (CW+1)'(w_cons);
        // Room for a whole word after this cycle's fill and drain.
        w_room    = (32'(w_cnt_nxt) + 32'd2) <= 32'(QDEPTH);
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_state <= ST_IDLE;
            r_fa    <= RESET_PC & ~32'd3;
            r_euia  <= RESET_PC & ~32'd3;
            r_qpc   <= RESET_PC;
            r_req   <= 1'b0;
            r_skip  <= RESET_PC[1];
        end else if (CE) begin
            if (JMP) begin
                r_qpc  <= {JMPA[31:1], 1'b0};
                r_fa   <= {JMPA[31:2], 2'b00};
                r_skip <= JMPA[1];
            end else begin
                r_qpc  <= r_qpc + {29'd0, w_cons, 1'b0};
            end

            case (r_state)
                ST_IDLE: begin
                    if (!JMP && w_room) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                        r_euia  <= r_fa;
                    end
                end
                ST_FETCH: begin
                    if (EUIACK) begin
                        if (JMP) begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_fa   <= r_fa + 32'd4;
                            r_skip <= 1'b0;
                            if (w_room) begin
                                r_euia <= r_fa + 32'd4;
                            end else begin
                                r_state <= ST_IDLE;
                                r_req   <= 1'b0;
                            end
                        end
                    end else if (JMP) begin
                        // Request already on the bus: keep it until acked, then drop its data.
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (EUIACK) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESn && CE && !JMP)
            assert (QCONS <= QV)
            else $warning("v810_ifetch: QCONS %0d above QV %0d, clamped", QCONS, QV);
    end

    v810_ifq #(
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_ifq (
        .i_clk    (CLK),
        .i_rst_n  (RESn),
        .i_en     (CE),
        .i_flush  (JMP),
        .i_wr_n   (w_wr_n),
        .i_wr_dat (w_wr_dat),
        .i_rd_n   (w_cons),
        .o_head   (QD),
        .o_cnt    (w_cnt)
    );

    assign EUIA   = r_euia;
    assign EUIREQ = r_req;
    assign QPC    = r_qpc;
    assign QV     = w_qv;

endmodule

// File: tb/tb_v810_ifetch.sv
// Directed bench for v810_ifetch: reset, fill/drain, full queue, wrap, redirect and flush cases.
module tb_v810_ifetch;

    logic        CLK;
    logic        RESn;
    logic        CE;
    logic        JMP;
    logic [31:0] JMPA;
    logic [31:0] EUIA;
    logic        EUIREQ;
    logic [31:0] EUID;
    logic        EUIACK;
    logic [31:0] QD;
    logic [31:0] QPC;
    logic [1:0]  QV;
    logic [1:0]  QCONS;

    int n_vec;
    int n_miss;

    v810_ifetch dut (
        .CLK    (CLK),
        .RESn   (RESn),
        .CE     (CE),
        .JMP    (JMP),
        .JMPA   (JMPA),
        .EUIA   (EUIA),
        .EUIREQ (EUIREQ),
        .EUID   (EUID),
        .EUIACK (EUIACK),
        .QD     (QD),
        .QPC    (QPC),
        .QV     (QV),
        .QCONS  (QCONS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_q(input string tag, input logic [1:0] qv, input logic [31:0] qpc);
        check_vec({tag, ".qv"}, {30'd0, QV}, {30'd0, qv});
        check_vec({tag, ".qpc"}, QPC, qpc);
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
        check_vec({tag, ".req"}, {31'd0, EUIREQ}, {31'd0, req});
        check_vec({tag, ".euia"}, EUIA, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        RESn = 1'b0; CE = 1'b1; JMP = 1'b0; JMPA = 32'h0;
        EUID = 32'h0; EUIACK = 1'b0; QCONS = 2'd0;

        repeat (2) step();
        chk_bus("rst", 1'b0, 32'hFFFF_FFF0);
        chk_q("rst", 2'd0, 32'hFFFF_FFF0);

        RESn = 1'b1; CE = 1'b0;
        repeat (2) step();
        chk_bus("ce_low", 1'b0, 32'hFFFF_FFF0);

        CE = 1'b1;
        step();
        chk_bus("first_req", 1'b1, 32'hFFFF_FFF0);
        step();
        chk_bus("req_hold", 1'b1, 32'hFFFF_FFF0);

        EUIACK = 1'b1; EUID = 32'h1234_5678;
        step();
        EUIACK = 1'b0;
        chk_q("ack1", 2'd2, 32'hFFFF_FFF0);
        check_vec("ack1.qd", QD, 32'h1234_5678);
        chk_bus("ack1", 1'b1, 32'hFFFF_FFF4);

        EUIACK = 1'b1; EUID = 32'h9ABC_DEF0;
        step();
        chk_bus("full", 1'b0, 32'hFFFF_FFF4);
        repeat (3) step();
        EUIACK = 1'b0;
        chk_bus("full_hold", 1'b0, 32'hFFFF_FFF4);
        chk_q("full_hold", 2'd2, 32'hFFFF_FFF0);
        check_vec("full_hold.qd", QD, 32'h1234_5678);

        QCONS = 2'd2;
        step();
        QCONS = 2'd0;
        chk_q("drain", 2'd2, 32'hFFFF_FFF4);
        check_vec("drain.qd", QD, 32'h9ABC_DEF0);
        chk_bus("refetch", 1'b1, 32'hFFFF_FFF8);

        EUIACK = 1'b1; EUID = 32'h1111_2222; QCONS = 2'd2;
        step();
        chk_q("fill_cons", 2'd2, 32'hFFFF_FFF8);
        check_vec("fill_cons.qd", QD, 32'h1111_2222);
        chk_bus("fill_cons", 1'b1, 32'hFFFF_FFFC);

        EUID = 32'h3333_4444;
        step();
        EUIACK = 1'b0; QCONS = 2'd1;
        chk_bus("fa_wrap", 1'b1, 32'h0000_0000);
        chk_q("fa_wrap", 2'd2, 32'hFFFF_FFFC);
        check_vec("fa_wrap.qd", QD, 32'h3333_4444);

        step();
        chk_q("cons1", 2'd1, 32'hFFFF_FFFE);
        check_vec("cons1.qd_lo", {16'h0, QD[15:0]}, 32'h0000_3333);

        QCONS = 2'd2;
        step();
        QCONS = 2'd0;
        chk_q("over_cons", 2'd0, 32'h0000_0000);

        EUIACK = 1'b1; EUID = 32'h5555_6666;
        step();
        chk_q("at_zero", 2'd2, 32'h0000_0000);
        check_vec("at_zero.qd", QD, 32'h5555_6666);

        JMP = 1'b1; JMPA = 32'h0000_3000; EUID = 32'hDEAD_BEEF; QCONS = 2'd2;
        step();
        JMP = 1'b0; EUIACK = 1'b0; QCONS = 2'd0;
        chk_q("jmp_ack", 2'd0, 32'h0000_3000);
        check_vec("jmp_ack.req", {31'd0, EUIREQ}, 32'd0);
        step();
        chk_bus("fetch3000", 1'b1, 32'h0000_3000);

        JMP = 1'b1; JMPA = 32'h0000_5000;
        step();
        JMPA = 32'h0000_2000;
        chk_bus("flush", 1'b1, 32'h0000_3000);
        chk_q("flush", 2'd0, 32'h0000_5000);
        step();
        JMP = 1'b0;
        chk_bus("flush2", 1'b1, 32'h0000_3000);
        chk_q("flush2", 2'd0, 32'h0000_2000);

        EUIACK = 1'b1; EUID = 32'h7777_8888;
        step();
        EUIACK = 1'b0;
        chk_q("flush_done", 2'd0, 32'h0000_2000);
        check_vec("flush_done.req", {31'd0, EUIREQ}, 32'd0);
        step();
        chk_bus("fetch2000", 1'b1, 32'h0000_2000);

        JMP = 1'b1; JMPA = 32'h0000_1002;
        step();
        JMP = 1'b0; EUIACK = 1'b1; EUID = 32'h0BAD_0BAD;
        chk_bus("odd_flush", 1'b1, 32'h0000_2000);
        step();
        EUIACK = 1'b0;
        step();
        chk_bus("fetch1000", 1'b1, 32'h0000_1000);

        EUIACK = 1'b1; EUID = 32'hAAAA_BBBB;
        step();
        EUIACK = 1'b0;
        chk_q("odd", 2'd1, 32'h0000_1002);
        check_vec("odd.qd_lo", {16'h0, QD[15:0]}, 32'h0000_AAAA);
        chk_bus("odd", 1'b1, 32'h0000_1004);

        CE = 1'b0; EUIACK = 1'b1; EUID = 32'h1357_9BDF; QCONS = 2'd1;
        step();
        step();
        chk_q("ce_hold", 2'd1, 32'h0000_1002);
        chk_bus("ce_hold", 1'b1, 32'h0000_1004);
        CE = 1'b1; EUIACK = 1'b0; QCONS = 2'd0;

        #2;
        RESn = 1'b0;
        #1;
        chk_bus("async_rst", 1'b0, 32'hFFFF_FFF0);
        chk_q("async_rst", 2'd0, 32'hFFFF_FFF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
